// File: rtl/mul_issue_if.sv
// Request and result channels between dispatch/CDB and the multiply issue unit.
interface mul_issue_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_funct3;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;

  logic             res_valid;
  logic             res_ready;
  logic [TAG_W-1:0] res_tag;
  logic [31:0]      res_data;

  modport master (
    output req_valid, req_funct3, req_a, req_b, req_tag,
    input  req_ready,
    input  res_valid, res_tag, res_data,
    output res_ready
  );

  modport slave (
    input  req_valid, req_funct3, req_a, req_b, req_tag,
    output req_ready,
    output res_valid, res_tag, res_data,
    input  res_ready
  );
endinterface

// File: rtl/mul_issue_unit.sv
// In-order request FIFO feeding a 4-cycle non-pipelined multiplier, with flush and tagged result hold.
// Optional zero-operand bypass when MUL_ZERO_BYPASS_EN is defined.
module mul_issue_unit #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  mul_issue_if.slave  bus,
  output logic        mul_in_en,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_a_signed,
  output logic        mul_b_signed,
  input  logic        mul_idle,
  input  logic        mul_out_en,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]      a_mem_q   [DEPTH];
  logic [31:0]      b_mem_q   [DEPTH];
  logic [1:0]       f3_mem_q  [DEPTH];
  logic [TAG_W-1:0] tag_mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, discard_q, discard_d;
  logic [1:0]       fl_f3_q, fl_f3_d;
  logic [TAG_W-1:0] fl_tag_q, fl_tag_d;
  logic             res_valid_q, res_valid_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic [31:0]      res_data_q, res_data_d;

  logic [31:0]      head_a_s, head_b_s;
  logic [1:0]       head_f3_s;
  logic [TAG_W-1:0] head_tag_s;
  logic             head_valid_s, push_s, issue_s, zero_s, bypass_s, capture_s;

  assign head_a_s     = a_mem_q[rd_ptr_q];
  assign head_b_s     = b_mem_q[rd_ptr_q];
  assign head_f3_s    = f3_mem_q[rd_ptr_q];
  assign head_tag_s   = tag_mem_q[rd_ptr_q];
  assign head_valid_s = (cnt_q != {CW{1'b0}});

  // Count-based only: a same-cycle pop never re-opens a full FIFO.
  assign bus.req_ready = (cnt_q != CW'(DEPTH));
  assign push_s        = bus.req_valid && bus.req_ready && !flush;
  assign issue_s       = head_valid_s && !busy_q && mul_idle &&
                         (!res_valid_q || bus.res_ready) && !flush;
`ifdef MUL_ZERO_BYPASS_EN
  assign zero_s        = (head_a_s == 32'd0) || (head_b_s == 32'd0);
`else
  assign zero_s        = 1'b0;
`endif
  assign bypass_s      = issue_s && zero_s;
  assign capture_s     = busy_q && mul_out_en;

  assign mul_in_en     = issue_s && !zero_s;
  assign mul_a         = head_a_s;
  assign mul_b         = head_b_s;
  assign mul_a_signed  = (head_f3_s == 2'b01) || (head_f3_s == 2'b10);
  assign mul_b_signed  = (head_f3_s == 2'b01);

  assign bus.res_valid = res_valid_q;
  assign bus.res_tag   = res_tag_q;
  assign bus.res_data  = res_data_q;

  // Next-state for pointers, occupancy, in-flight tracking and the result holder.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    discard_d   = discard_q;
    fl_f3_d     = fl_f3_q;
    fl_tag_d    = fl_tag_q;
    res_valid_d = res_valid_q;
    res_tag_d   = res_tag_q;
    res_data_d  = res_data_q;
    if (flush) begin
      wr_ptr_d    = {PW{1'b0}};
      rd_ptr_d    = {PW{1'b0}};
      cnt_d       = {CW{1'b0}};
      res_valid_d = 1'b0;
      // The multiplier cannot be aborted; remember to drop its pending result.
      if (capture_s) begin
        busy_d    = 1'b0;
        discard_d = 1'b0;
      end else if (busy_q) begin
        discard_d = 1'b1;
      end else begin
        discard_d = discard_q;
      end
    end else begin
      if (push_s) wr_ptr_d = wr_ptr_q + PW'(1);
      else        wr_ptr_d = wr_ptr_q;
      if (issue_s) rd_ptr_d = rd_ptr_q + PW'(1);
      else         rd_ptr_d = rd_ptr_q;
      case ({push_s, issue_s})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
      if (res_valid_q && bus.res_ready) res_valid_d = 1'b0;
      else                              res_valid_d = res_valid_q;
      if (mul_in_en) begin
        busy_d   = 1'b1;
        fl_f3_d  = head_f3_s;
        fl_tag_d = head_tag_s;
      end else if (capture_s) begin
        busy_d    = 1'b0;
        discard_d = 1'b0;
        if (!discard_q) begin
          res_valid_d = 1'b1;
          res_tag_d   = fl_tag_q;
          res_data_d  = (fl_f3_q == 2'b00) ? mul_lo : mul_hi;
        end else begin
          res_tag_d   = res_tag_q;
        end
      end else if (bypass_s) begin
        res_valid_d = 1'b1;
        res_tag_d   = head_tag_s;
        res_data_d  = 32'd0;
      end else begin
        busy_d = busy_q;
      end
    end
  end

  // Control and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      cnt_q       <= {CW{1'b0}};
      busy_q      <= 1'b0;
      discard_q   <= 1'b0;
      fl_f3_q     <= 2'b00;
      fl_tag_q    <= {TAG_W{1'b0}};
      res_valid_q <= 1'b0;
      res_tag_q   <= {TAG_W{1'b0}};
      res_data_q  <= 32'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      discard_q   <= discard_d;
      fl_f3_q     <= fl_f3_d;
      fl_tag_q    <= fl_tag_d;
      res_valid_q <= res_valid_d;
      res_tag_q   <= res_tag_d;
      res_data_q  <= res_data_d;
    end
  end

  // FIFO storage; entries are only read once occupancy covers them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      a_mem_q[wr_ptr_q]   <= bus.req_a;
      b_mem_q[wr_ptr_q]   <= bus.req_b;
      f3_mem_q[wr_ptr_q]  <= bus.req_funct3;
      tag_mem_q[wr_ptr_q] <= bus.req_tag;
    end
  end
endmodule

// File: tb/tb_mul_issue_unit.sv
// Directed bench for mul_issue_unit with a behavioural 4-cycle multiplier.
module tb_mul_issue_unit;
  logic        clk = 1'b0;
  logic        rst, flush;
  logic        mul_in_en, mul_a_signed, mul_b_signed, mul_idle, mul_out_en;
  logic [31:0] mul_a, mul_b, mul_hi, mul_lo;

  mul_issue_if #(.TAG_W(4)) bus ();

  mul_issue_unit #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus),
    .mul_in_en(mul_in_en), .mul_a(mul_a), .mul_b(mul_b),
    .mul_a_signed(mul_a_signed), .mul_b_signed(mul_b_signed),
    .mul_idle(mul_idle), .mul_out_en(mul_out_en),
    .mul_hi(mul_hi), .mul_lo(mul_lo)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: samples mul_in_en at edge E1, pulses mul_out_en after E4.
  logic        m_run;
  logic [1:0]  m_cnt;
  logic [63:0] m_prod, a_ext, b_ext;
  assign a_ext    = mul_a_signed ? {{32{mul_a[31]}}, mul_a} : {32'd0, mul_a};
  assign b_ext    = mul_b_signed ? {{32{mul_b[31]}}, mul_b} : {32'd0, mul_b};
  assign mul_hi   = m_prod[63:32];
  assign mul_lo   = m_prod[31:0];
  assign mul_idle = !m_run;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 1'b0; m_cnt <= 2'd0; mul_out_en <= 1'b0; m_prod <= 64'd0;
    end else begin
      mul_out_en <= 1'b0;
      if (mul_in_en) begin
        m_run <= 1'b1; m_cnt <= 2'd3; m_prod <= a_ext * b_ext;
      end else if (m_run) begin
        if (m_cnt == 2'd1) begin
          mul_out_en <= 1'b1; m_run <= 1'b0;
        end
        m_cnt <= m_cnt - 2'd1;
      end
    end
  end

  typedef struct { logic [3:0] tag; logic [31:0] data; int cyc; } rec_t;
  rec_t rq[$];
  int cyc = 0;
  int n_issue = 0;
  int total = 0;
  int bad = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) rq.push_back('{bus.res_tag, bus.res_data, cyc});
    if (!rst && mul_in_en) n_issue++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++; bad++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  // Called just after a rising edge; returns the cycle number of the accepting edge.
  task automatic push(input logic [1:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, output int t);
    int g;
    bus.req_valid = 1'b1; bus.req_funct3 = f3; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
    g = 0;
    while (!bus.req_ready && g < 50) begin @(posedge clk); #1; g++; end
    if (g >= 50) timeout("push_ready");
    @(posedge clk); #1;
    t = cyc;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_n(input int n, input string name);
    int g;
    g = 0;
    while (rq.size() < n && g < 100) begin @(negedge clk); g++; end
    if (rq.size() < n) timeout(name);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input string name);
    int g;
    g = 0;
    while (bus.res_valid !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    if (bus.res_valid !== 1'b1) timeout(name);
  endtask

  typedef struct { logic [1:0] f3; logic [31:0] a; logic [31:0] b; logic [3:0] tag; logic [31:0] exp; } vec_t;
  vec_t vt[7];

  initial begin
    int t, i0, tp[5];
    logic unstable;
    vt[0] = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 4'd3, 32'hFFFFFFEB};
    vt[1] = '{2'b01, 32'h80000000, 32'h80000000, 4'd1, 32'h40000000};
    vt[2] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2, 32'hFFFFFFFE};
    vt[3] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd4, 32'hFFFFFFFF};
    vt[4] = '{2'b00, 32'h12345678, 32'h00000010, 4'd5, 32'h23456780};
    vt[5] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd6, 32'h00000000};
    vt[6] = '{2'b01, 32'hFFFFFFFF, 32'h00000002, 4'd7, 32'hFFFFFFFF};

    rst = 1'b1; flush = 1'b0; bus.res_ready = 1'b1;
    bus.req_valid = 1'b0; bus.req_funct3 = 2'b00; bus.req_a = 32'd0; bus.req_b = 32'd0; bus.req_tag = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid", bus.res_valid, 1'b0);
    chk("rst_res_tag", bus.res_tag, 4'd0);
    chk("rst_res_data", bus.res_data, 32'd0);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_mul_in_en", mul_in_en, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 7; k++) begin
      rq.delete();
      push(vt[k].f3, vt[k].a, vt[k].b, vt[k].tag, t);
      wait_n(1, "vec_result");
      if (rq.size() > 0) begin
        chk($sformatf("vec%0d_data", k), rq[0].data, vt[k].exp);
        chk($sformatf("vec%0d_tag", k), rq[0].tag, vt[k].tag);
        chk($sformatf("vec%0d_latency", k), rq[0].cyc - t, 5);
      end
    end

    // Back-to-back: five pushes, FIFO fills after the fifth.
    rq.delete();
    for (int k = 0; k < 5; k++) push(2'b00, k + 1, 32'd3, k[3:0], tp[k]);
    chk("b2b_full_ready", bus.req_ready, 1'b0);
    wait_n(5, "b2b_results");
    if (rq.size() == 5) begin
      chk("b2b_first_latency", rq[0].cyc - tp[0], 5);
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("b2b%0d_tag", k), rq[k].tag, k);
        chk($sformatf("b2b%0d_data", k), rq[k].data, 3 * (k + 1));
        if (k > 0) chk($sformatf("b2b%0d_spacing", k), rq[k].cyc - rq[k-1].cyc, 5);
      end
    end

    // Backpressure: first result held, second not issued.
    rq.delete();
    bus.res_ready = 1'b0;
    push(2'b00, 32'd6, 32'd7, 4'd5, t);
    push(2'b00, 32'd9, 32'd9, 4'd6, t);
    wait_valid("hold_first");
    i0 = n_issue;
    unstable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b1 || bus.res_data !== 32'd42 || bus.res_tag !== 4'd5) unstable = 1'b1;
    end
    chk("hold_stable", unstable, 1'b0);
    chk("hold_no_issue", n_issue - i0, 0);
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    wait_n(2, "hold_release");
    if (rq.size() == 2) begin
      chk("hold_r0", {rq[0].tag, rq[0].data}, {4'd5, 32'd42});
      chk("hold_r1", {rq[1].tag, rq[1].data}, {4'd6, 32'd81});
      chk("hold_spacing", rq[1].cyc - rq[0].cyc, 5);
    end

    // Flush two cycles after issue, with two queued and a push colliding with the flush.
    rq.delete();
    i0 = n_issue;
    push(2'b00, 32'h11, 32'd2, 4'd1, t);
    push(2'b00, 32'h22, 32'd2, 4'd2, t);
    push(2'b00, 32'h33, 32'd2, 4'd3, t);
    flush = 1'b1;
    bus.req_valid = 1'b1; bus.req_a = 32'h44; bus.req_b = 32'd2; bus.req_tag = 4'd15;
    @(posedge clk); #1;
    flush = 1'b0; bus.req_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("flush_issues", n_issue - i0, 1);
    chk("flush_no_result", rq.size(), 0);
    chk("flush_res_valid", bus.res_valid, 1'b0);
    chk("flush_req_ready", bus.req_ready, 1'b1);
    push(2'b11, 32'h00010000, 32'h00010000, 4'd7, t);
    wait_n(1, "post_flush");
    if (rq.size() > 0) begin
      chk("post_flush_data", rq[0].data, 32'd1);
      chk("post_flush_tag", rq[0].tag, 4'd7);
      chk("post_flush_latency", rq[0].cyc - t, 5);
    end

    // Asynchronous reset with a full FIFO and a held result.
    bus.res_ready = 1'b0;
    for (int k = 0; k < 5; k++) push(2'b00, 32'd3, 32'd5, 4'd2, t);
    chk("pre_rst_full", bus.req_ready, 1'b0);
    wait_valid("pre_rst_valid");
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_res_valid", bus.res_valid, 1'b0);
    chk("arst_res_data", bus.res_data, 32'd0);
    chk("arst_res_tag", bus.res_tag, 4'd0);
    chk("arst_req_ready", bus.req_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.res_ready = 1'b1;
    rq.delete();
    @(posedge clk); #1;
    push(2'b00, 32'h0000FFFF, 32'h0000FFFF, 4'd4, t);
    wait_n(1, "post_rst");
    if (rq.size() > 0) chk("post_rst_result", {rq[0].tag, rq[0].data}, {4'd4, 32'hFFFE0001});

`ifdef MUL_ZERO_BYPASS_EN
    rq.delete();
    i0 = n_issue;
    push(2'b00, 32'd0, 32'd5, 4'd9, t);
    wait_n(1, "bypass");
    if (rq.size() > 0) begin
      chk("bypass_data", rq[0].data, 32'd0);
      chk("bypass_tag", rq[0].tag, 4'd9);
      chk("bypass_latency", rq[0].cyc - t, 1);
    end
    chk("bypass_no_issue", n_issue - i0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
